// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with 16x oversampling, byte strobe and framing-error pulse
module uart_rx_byte #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done_tick,
  output logic                 frame_error,
  output logic                 busy
);

  // Clocks per oversample tick; must be at least 2.
  localparam int DIV   = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV);
  localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic                 start_det;
  logic [3:0]           s_cnt;
  logic [N_W-1:0]       n_cnt;
  logic [DATA_BITS-1:0] shreg;

  assign tick      = (div_cnt == DIV_LAST);
  assign start_det = (state == IDLE) && !rx_s;

  // Two-flop synchronizer; the line idles high so both flops reset to 1.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Oversample tick divider, restarted at the start edge so mid-bit sampling phase is fixed.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame state machine with registered byte strobe, error pulse and busy flag.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
      data_out     <= '0;
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == 4'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                // Line was back high at mid start bit: a glitch, not a frame.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              s_cnt <= '0;
              n_cnt <= n_cnt + 1'b1;
              if (n_cnt == N_LAST) begin
                state <= STOP;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              if (rx_s) begin
                data_out     <= shreg;
                rx_done_tick <= 1'b1;
                state        <= IDLE;
                busy         <= 1'b0;
              end else begin
                // Bad stop bit: drop the byte and wait out any break condition.
                frame_error <= 1'b1;
                state       <= WAIT_IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

  localparam int BIT_CLKS = 160;

  logic       clk_100MHz;
  logic       reset_n;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done_tick;
  logic       frame_error;
  logic       busy;

  int         n_cmp;
  int         n_bad;
  int         fe_cnt;
  int         both_cnt;
  logic [7:0] got_q[$];
  logic [7:0] burst[8];

  uart_rx_byte #(
    .CLK_FREQ_HZ(1_536_000),
    .BAUD_RATE  (9600),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .rx          (rx),
    .data_out    (data_out),
    .rx_done_tick(rx_done_tick),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Record strobes on the falling edge, away from the active edge.
  always @(negedge clk_100MHz) begin
    if (rx_done_tick) got_q.push_back(data_out);
    if (frame_error) fe_cnt++;
    if (rx_done_tick && frame_error) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop_bit;
    wait_clks(BIT_CLKS);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    fe_cnt   = 0;
    both_cnt = 0;
    burst    = '{8'h53, 8'h49, 8'h4D, 8'h4F, 8'h4E, 8'h53, 8'h41, 8'h59};

    // 1. Reset
    rx      = 1'b1;
    reset_n = 1'b0;
    wait_clks(5);
    check("reset data_out", data_out, 8'h00);
    check("reset rx_done_tick", rx_done_tick, 1'b0);
    check("reset frame_error", frame_error, 1'b0);
    check("reset busy", busy, 1'b0);
    reset_n = 1'b1;
    wait_clks(20);
    check("post-reset busy", busy, 1'b0);

    // 2. Single byte 'A'
    got_q.delete();
    send_bits(8'h41, 1'b1);
    wait_clks(20);
    check("single count", got_q.size(), 1);
    if (got_q.size() >= 1) check("single data", got_q[0], 8'h41);
    check("single data_out held", data_out, 8'h41);
    check("single no frame_error", fe_cnt, 0);

    // 3. Back-to-back burst "SIMONSAY"
    got_q.delete();
    for (int i = 0; i < 8; i++) send_bits(burst[i], 1'b1);
    wait_clks(20);
    check("burst count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check($sformatf("burst byte %0d", i), got_q[i], burst[i]);
    end
    check("burst no frame_error", fe_cnt, 0);

    // 4. Glitch rejected at mid start bit
    got_q.delete();
    rx = 1'b0;
    wait_clks(10);
    check("glitch busy rises", busy, 1'b1);
    wait_clks(20);
    rx = 1'b1;
    wait_clks(90);
    check("glitch busy drops", busy, 1'b0);
    check("glitch no strobe", got_q.size(), 0);
    check("glitch data_out kept", data_out, 8'h59);
    wait_clks(50);
    send_bits(8'h37, 1'b1);
    wait_clks(20);
    check("after glitch count", got_q.size(), 1);
    if (got_q.size() >= 1) check("after glitch data", got_q[0], 8'h37);

    // 5. Framing error followed by a held-low line
    got_q.delete();
    send_bits(8'h5A, 1'b0);
    wait_clks(500);
    check("ferr pulse count", fe_cnt, 1);
    check("ferr no strobe", got_q.size(), 0);
    check("ferr data_out kept", data_out, 8'h37);
    check("ferr busy during break", busy, 1'b1);
    rx = 1'b1;
    wait_clks(5);
    check("ferr busy after release", busy, 1'b0);
    wait_clks(50);
    send_bits(8'h21, 1'b1);
    wait_clks(20);
    check("after ferr count", got_q.size(), 1);
    if (got_q.size() >= 1) check("after ferr data", got_q[0], 8'h21);
    check("after ferr fe count", fe_cnt, 1);

    // 6. Reset in the middle of data bit 3 of 0x96
    got_q.delete();
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h96 >> i);
      wait_clks(BIT_CLKS);
    end
    rx = 1'(8'h96 >> 3);
    wait_clks(BIT_CLKS / 2);
    check("midframe busy before reset", busy, 1'b1);
    @(negedge clk_100MHz);
    reset_n = 1'b0;
    #1;
    check("midframe reset busy", busy, 1'b0);
    check("midframe reset data_out", data_out, 8'h00);
    check("midframe reset rx_done_tick", rx_done_tick, 1'b0);
    rx = 1'b1;
    wait_clks(10);
    reset_n = 1'b1;
    wait_clks(BIT_CLKS * 2);
    check("midframe no strobe", got_q.size(), 0);
    send_bits(8'h96, 1'b1);
    wait_clks(20);
    check("after reset count", got_q.size(), 1);
    if (got_q.size() >= 1) check("after reset data", got_q[0], 8'h96);
    check("final fe count", fe_cnt, 1);
    check("never both pulses", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
